// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the nibble-serial ALU controller
package alu_pkg;

  // Sequencer states; the fourth 2-bit code is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_adder_slice.sv
// rtl/nibble_adder_slice.sv - combinational 4-bit ripple adder slice
// Ports:
//   a, b  : nibble operands (b already inverted by the controller for subtract)
//   cin   : carry into bit 0
//   sum   : 4-bit sum
//   cout  : carry out of bit 3
module nibble_adder_slice
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// rtl/nibble_serial_alu_ctrl.sv - WIDTH-bit add/sub sequenced over one 4-bit adder slice
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, sub, a, b: operation request and operands, sampled only in IDLE
//   busy            : high in RUN and DONE
//   done            : one-cycle pulse, result and flags valid from this cycle
//   result          : sum/difference, held until the next accepted start
//   z_flag, n_flag, v_flag : zero, negative, signed overflow of the final result
module nibble_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z_flag,
  output logic             n_flag,
  output logic             v_flag
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t state, next_state;

  logic [CW-1:0]       counter;
  logic [WIDTH-1:0]    a_r, b_r;
  logic                sub_r;
  logic                carry;

  logic [CW+1:0]       base;
  logic [NIBBLE_W-1:0] a_nib, b_nib, sum_nib;
  logic                cout_nib;
  logic                last_nib;
  logic [WIDTH-1:0]    s_final;

  // Bit offset of the nibble being processed this cycle.
  assign base     = {counter, 2'b00};
  assign a_nib    = a_r[base +: NIBBLE_W];
  assign b_nib    = (sub_r == OP_SUB) ? ~b_r[base +: NIBBLE_W] : b_r[base +: NIBBLE_W];
  assign last_nib = (counter == LAST);

  nibble_adder_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (sum_nib),
    .cout (cout_nib)
  );

  // Final result as it will look after the top nibble is written; lets the
  // flags be registered on the same edge as the last nibble.
  assign s_final = {sum_nib, result[WIDTH-NIBBLE_W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = start ? RUN : IDLE;
      RUN:     next_state = last_nib ? DONE : RUN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      carry   <= 1'b0;
      result  <= '0;
      z_flag  <= 1'b0;
      n_flag  <= 1'b0;
      v_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= sub;
            carry   <= sub;   // +1 completes the two's-complement of b
            counter <= '0;
          end
        end
        RUN: begin
          result[base +: NIBBLE_W] <= sum_nib;
          carry                    <= cout_nib;
          if (last_nib) begin
            z_flag <= (s_final == '0);
            n_flag <= sum_nib[NIBBLE_W-1];
            if (sub_r == OP_SUB)
              v_flag <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum_nib[NIBBLE_W-1] != a_r[WIDTH-1]);
            else
              v_flag <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_nib[NIBBLE_W-1] != a_r[WIDTH-1]);
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// tb/tb_nibble_serial_alu_ctrl.sv - scoreboard bench for the nibble-serial ALU controller
module tb_nibble_serial_alu_ctrl;

  localparam int W    = 16;
  localparam int NIB  = W / 4;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic         z_flag, n_flag, v_flag;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  nibble_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .z_flag (z_flag),
    .n_flag (n_flag),
    .v_flag (v_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain signed integer arithmetic, overflow = out of W-bit signed range.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    int sx, sy, full;
    logic [31:0] fw;
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    full = s ? (sx - sy) : (sx + sy);
    fw   = full;
    e.res = fw[W-1:0];
    e.z   = (e.res == '0);
    e.n   = e.res[W-1];
    e.v   = (full > SMAX) || (full < SMIN);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("z_flag", 32'(z_flag), 32'(e.z));
        check("n_flag", 32'(n_flag), 32'(e.n));
        check("v_flag", 32'(v_flag), 32'(e.v));
      end
    end
  end

  // Issue one operation from IDLE and wait for it to finish. If poke>0, a
  // stray start with a different operand is driven in that busy cycle.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs, input int poke);
    int cnt;
    @(negedge clk);
    start = 1'b1; a = xa; b = xb; sub = xs;
    exp_q.push_back(model(xa, xb, xs));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      if (cnt == poke) begin
        start = 1'b1; a = 16'hAAAA;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 32'(cnt), 32'(NIB + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags",  32'({z_flag, n_flag, v_flag}), 32'd0);
    rst = 1'b0;

    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'h1234, 16'h1234, 1'b1, 0);
    do_op(16'h0003, 16'h0005, 1'b1, 0);
    do_op(16'h0001, 16'h0001, 1'b0, 2);

    // Abort mid-RUN: result currently 0x0002, becomes partially 0x0000 here,
    // so seed a visibly nonzero result/flags first.
    do_op(16'h0003, 16'h0005, 1'b1, 0);
    @(negedge clk);
    start = 1'b1; a = 16'h00FF; b = 16'h0001; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_done",   32'(done),   32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags",  32'({z_flag, n_flag, v_flag}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0010, 16'h0020, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
